// File: rtl/hilo_muldiv_pkg.sv
// Purpose: shared encodings for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam int MD_WIDTH_DEFAULT = 32;

    // Width of the iteration counter for a given operand width.
    function automatic int md_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Purpose: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller registers acc_out every RUN cycle.
//
// Ports:
//   is_div  - 1 selects the divide step, 0 the multiply step
//   acc_in  - {upper, lower} accumulator: {partial product, multiplier} or {remainder, dividend/quotient}
//   opnd    - multiplicand magnitude or divisor magnitude
//   acc_out - accumulator after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right; the carry lands in the MSB.
        add_sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
        // Divide: shift the next dividend bit into the remainder and try the subtraction
        // at WIDTH+1 bits so the borrow tells us whether to restore.
        trial   = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_out = {add_sum, acc_in[WIDTH-1:1]};
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Purpose: iterative mult/div unit owning the HI/LO pair, with mthi/mtlo writes and hazard stall.
// Latency: accept edge + WIDTH RUN edges + 1 FIX edge; Done pulses the cycle after HI/LO update.
// Backpressure: Start held until accepted in IDLE; Stall asserted while Busy and ID needs the unit.
//
// Ports:
//   Clock, Reset_n      - rising-edge clock, async active-low reset
//   Start, Op, A, B     - mult/div request; operands and op sampled on accept
//   Mt_Hi, Mt_Lo        - write A into Hi / Lo when idle and no Start
//   Mf_Req              - ID stage holds mfhi/mflo
//   Hi, Lo              - architectural HI/LO registers
//   Busy, Stall         - operation in progress / freeze PC and IF/ID
//   Done, Div0          - one-cycle result pulse / divisor was zero
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Mt_Hi,
    input  logic             Mt_Lo,
    input  logic             Mf_Req,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             Div0
);

    localparam int              CNT_W    = md_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand (mult) or divisor (div) magnitude
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, div0_q, div0_d;

    logic               op_signed, a_neg, b_neg, is_div, opnd_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // The op's MSB distinguishes divide from multiply in the encoding.
    assign is_div = op_q[1];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;

        // Operand conditioning for a new request; signed ops have LSB clear.
        op_signed = ~Op[0];
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;

        // Sign correction applied in FIX. The remainder follows the dividend, which also
        // turns the divide-by-zero remainder (|A|) back into the raw A.
        opnd_zero = (opnd_q == '0);
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            MD_IDLE: begin
                if (Start) begin
                    op_d     = md_op_e'(Op);
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    opnd_d   = Op[1] ? b_mag : a_mag;
                    acc_d    = {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
                    cnt_d    = '0;
                    state_d  = MD_RUN;
                end else begin
                    if (Mt_Hi) hi_d = A;
                    if (Mt_Lo) lo_d = A;
                end
            end
            MD_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = MD_FIX;
            end
            MD_FIX: begin
                if (is_div) begin
                    hi_d   = rem_fix;
                    lo_d   = opnd_zero ? {WIDTH{1'b1}} : quo_fix;
                    div0_d = opnd_zero;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= MD_IDLE;
            op_q     <= MD_OP_MULT;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign Busy  = (state_q != MD_IDLE);
    assign Stall = Busy & (Start | Mf_Req | Mt_Hi | Mt_Lo);
    assign Done  = done_q;
    assign Div0  = div0_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          Clock, Reset_n, Start, Mt_Hi, Mt_Lo, Mf_Req;
    logic [1:0]    Op;
    logic [W-1:0]  A, B, Hi, Lo;
    logic          Busy, Stall, Done, Div0;

    int n_vec = 0;
    int n_mis = 0;

    hilo_muldiv #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Mt_Hi(Mt_Hi), .Mt_Lo(Mt_Lo), .Mf_Req(Mf_Req), .Hi(Hi), .Lo(Lo),
        .Busy(Busy), .Stall(Stall), .Done(Done), .Div0(Div0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (sampling 1 time unit after each edge) for Done; lat counts edges from accept.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!Done && lat < 100) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    // Called 1 time unit after an edge with the unit idle (or in its Done cycle).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic d0, output int lat);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(lat);
        hi = Hi; lo = Lo; d0 = Div0;
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo, output logic d0);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d0 = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; d0 = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    hi = 32'(r); lo = 32'(q);
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom_range(0, 20);
            1: v = 32'hFFFF_FFFF - $urandom_range(0, 20);
            2: case ($urandom_range(0, 2))
                   0: v = 32'h8000_0000;
                   1: v = 32'h0000_0000;
                   default: v = 32'h7FFF_FFFF;
               endcase
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] hi, lo, ehi, elo;
        logic        d0, ed0;
        int          lat, stall_cnt, stall_bad;

        tbl[0] = '{MD_OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1] = '{MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2] = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{MD_OP_DIVU,  32'd100,        32'd7,          32'd2,         32'd14,        1'b0};
        tbl[4] = '{MD_OP_DIVU,  32'd100,        32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        tbl[6] = '{MD_OP_DIV,   32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        tbl[7] = '{MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        tbl[8] = '{MD_OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        tbl[9] = '{MD_OP_MULTU, 32'h1234_5678, 32'd0,          32'd0,         32'd0,         1'b0};

        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        Mt_Hi = 1'b0; Mt_Lo = 1'b0; Mf_Req = 1'b0;

        // Reset state
        repeat (3) @(posedge Clock);
        #1;
        check("reset_hi", Hi, 32'd0);
        check("reset_lo", Lo, 32'd0);
        check("reset_busy_done_div0_stall", 32'({Busy, Done, Div0, Stall}), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Directed table, each followed by a check that Done/Div0 last one cycle only
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, hi, lo, d0, lat);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            check($sformatf("tbl%0d_div0", i), 32'(d0), 32'(tbl[i].d0));
            @(posedge Clock); #1;
            check($sformatf("tbl%0d_pulse_end", i), 32'({Done, Div0}), 32'd0);
        end

        // Back-to-back: second Start issued in the first op's Done cycle
        run_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, d0, lat);
        check("b2b_first_lo", lo, 32'hFFFF_FFFD);
        run_op(MD_OP_DIVU, 32'd100, 32'd7, hi, lo, d0, lat);
        check("b2b_second_latency", 32'(lat), 32'(LAT));
        check("b2b_second_hi", hi, 32'd2);
        check("b2b_second_lo", lo, 32'd14);
        @(posedge Clock); #1;

        // mthi + mtlo together while idle
        Mt_Hi = 1'b1; Mt_Lo = 1'b1; A = 32'h0000_CAFE;
        @(posedge Clock); #1;
        Mt_Hi = 1'b0; Mt_Lo = 1'b0;
        check("mt_both_hi", Hi, 32'h0000_CAFE);
        check("mt_both_lo", Lo, 32'h0000_CAFE);

        // Start and Mt_Hi in the same idle cycle: Start wins
        Start = 1'b1; Mt_Hi = 1'b1; Op = MD_OP_MULTU; A = 32'd2; B = 32'd3;
        @(posedge Clock); #1;
        Start = 1'b0; Mt_Hi = 1'b0;
        check("start_wins_hi_kept", Hi, 32'h0000_CAFE);
        check("start_wins_busy", 32'(Busy), 32'd1);
        wait_done(lat);
        check("start_wins_lo", Lo, 32'd6);
        @(posedge Clock); #1;

        // Mf_Req held through a MULT; Mt_Hi while busy must be ignored
        Mf_Req = 1'b1; Start = 1'b1; Op = MD_OP_MULT; A = 32'd3; B = 32'd5;
        @(posedge Clock); #1;
        Start = 1'b0; Mt_Hi = 1'b1; A = 32'h0000_1234;
        stall_cnt = 0; stall_bad = 0; lat = 1;
        while (!Done && lat < 100) begin
            if (Stall) stall_cnt++;
            if (Stall !== 1'b1 || Busy !== 1'b1) stall_bad++;
            @(posedge Clock); #1;
            lat++;
        end
        check("stall_busy_cycles", 32'(stall_cnt), 32'(LAT - 1));
        check("stall_bad_cycles", 32'(stall_bad), 32'd0);
        check("stall_done_cycle", 32'({Stall, Busy, Done}), 32'b001);
        check("mt_busy_ignored_hi", Hi, 32'd0);
        check("mult_3x5_lo", Lo, 32'd15);
        Mf_Req = 1'b0;
        @(posedge Clock); #1;     // Mt_Hi still high, now idle
        Mt_Hi = 1'b0;
        check("mt_after_done_hi", Hi, 32'h0000_1234);
        check("mt_after_done_lo", Lo, 32'd15);

        // Reset mid-operation
        Start = 1'b1; Op = MD_OP_DIV; A = 32'd1000; B = 32'd3;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        #1;
        check("abort_busy_done", 32'({Busy, Done}), 32'd0);
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        run_op(MD_OP_MULT, 32'd3, 32'd5, hi, lo, d0, lat);
        check("post_reset_latency", 32'(lat), 32'(LAT));
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd15);

        // Randomized against the reference model, issued back-to-back
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = pick_operand();
            rb  = pick_operand();
            ref_model(rop, ra, rb, ehi, elo, ed0);
            run_op(rop, ra, rb, hi, lo, d0, lat);
            check($sformatf("rnd%0d_op%0d_a%0h_b%0h_hi", n, rop, ra, rb), hi, ehi);
            check($sformatf("rnd%0d_op%0d_a%0h_b%0h_lo", n, rop, ra, rb), lo, elo);
            check($sformatf("rnd%0d_div0", n), 32'(d0), 32'(ed0));
            if (lat != LAT) check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(LAT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with its own HI/LO register pair, sitting in the EX stage directly downstream of the control unit.
- Consumes the decoded mult/multu/div/divu, mthi/mtlo and mfhi/mflo requests.
- Drives the Stall line back to the hazard logic until a result is ready.
- One operation in flight at a time; HI/LO are architectural state owned by this block.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
Clock     in   1      system clock, rising edge
Reset_n   in   1      asynchronous, active-low reset
Start     in   1      request a mult/div; held by upstream until accepted
Op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on accept
A         in   WIDTH  rs operand (multiplicand / dividend)
B         in   WIDTH  rt operand (multiplier / divisor)
Mt_Hi     in   1      mthi: write A into Hi
Mt_Lo     in   1      mtlo: write A into Lo
Mf_Req    in   1      ID stage holds mfhi/mflo
Hi        out  WIDTH  HI register (mfhi source, remainder / upper product)
Lo        out  WIDTH  LO register (mflo source, quotient / lower product)
Busy      out  1      operation in progress
Stall     out  1      freeze PC and IF/ID
Done      out  1      one-cycle pulse: Hi/Lo just updated by mult/div
Div0      out  1      pulses with Done when divisor was zero

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, Div0=0, counter=0. Asserting reset mid-operation aborts the operation and clears Hi/Lo.
- States: IDLE, RUN, FIX.
- Accept = Start & (state==IDLE), on a rising edge.
  - Latch |A|, |B| (magnitudes for MULT/DIV; raw for MULTU/DIVU), the sign flags and Op.
  - Clear the counter and go to RUN.
- RUN: one radix-2 step per edge. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring shift-subtract.
- RUN lasts exactly WIDTH edges; when the counter reaches WIDTH-1, go to FIX.
- FIX (1 edge): apply sign correction and write Hi/Lo; Done=1 (registered) in the following cycle; state returns to IDLE.
- Signed multiply: the 2*WIDTH product is negated if sign(A)!=sign(B). Hi gets the upper half, Lo the lower half.
- Signed divide: quotient is negated if the signs differ; remainder takes the sign of the dividend. Lo = quotient, Hi = remainder.
- Divide by zero (B==0, signed or unsigned): normal latency, no sign correction. Lo = all ones, Hi = A, Div0 pulses with Done.
- Signed overflow (-2^(WIDTH-1) / -1): Lo = 0x80000000 (wrapped), Hi = 0. No flag.
- Latency: the accept edge is edge 1. Hi/Lo are updated on edge WIDTH+2 (34 for WIDTH=32). Busy=1 from after edge 1 through edge WIDTH+2. Done=1 in the cycle after edge WIDTH+2.
- Back-to-back operations: Start held high during the Done cycle is accepted on that cycle's edge. No idle bubble required.
- Start while Busy: not accepted, no side effect.
- Stall = Busy & (Start | Mf_Req | Mt_Hi | Mt_Lo). This is combinational from registered Busy and the ID-stage inputs.
- Mt_Hi/Mt_Lo in IDLE (Start=0): the register takes A at the edge. Both may be asserted together.
- Mt_* while Busy: ignored; the instruction is stalled and retried.
- Mt_* with Start in the same IDLE cycle: Start wins, Mt_* ignored. The control unit never issues both.
- Hi/Lo change only on FIX, Mt_* writes, or reset.

Decomposition:
- Shared package holds:
  - Op encodings MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU.
  - State encodings MD_IDLE, MD_RUN, MD_FIX.
  - Iteration-count width, $clog2(WIDTH).
- One sub-module, muldiv_step: combinational single iteration (shift-add or shift-subtract selected by an op bit). The top holds the FSM, counter, operand/accumulator registers, sign fix and HI/LO.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) -> Done on cycle 35 after the accept edge, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Div0=0.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). Then DIVU 100/7 started in the Done cycle -> Lo=14, Hi=2, accepted with no idle cycle.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064, Div0 and Done both high for exactly one cycle.
- Mf_Req high throughout a MULT -> Stall=1 every cycle while Busy, 0 in the Done cycle. Mt_Hi A=0x1234 while Busy is ignored; after Done, Mt_Hi A=0x1234 gives Hi=0x1234.
- Start DIV, pull Reset_n low at cycle 10 -> Busy, Done, Hi, Lo all 0 immediately. After release, a MULT 3*5 completes normally with Lo=15.
